// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: packed control bundle bit
// positions, ALUOp encodings, forwarding select codes and the bubble value.
package ctrl_pkg;

   // Bit positions inside the 8-bit packed control bundle
   localparam int CB_REG_WRITE  = 7;
   localparam int CB_MEM_TO_REG = 6;
   localparam int CB_MEM_READ   = 5;
   localparam int CB_MEM_WRITE  = 4;
   localparam int CB_ALU_SRC    = 3;
   localparam int CB_ALU_OP_HI  = 2;
   localparam int CB_ALU_OP_LO  = 1;
   localparam int CB_REG_DST    = 0;

   // ALUOp field encodings
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_OR    = 2'b10,
      ALU_RTYPE = 2'b11
   } alu_op_e;

   // EX operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // All-zero control: no writes, no memory access
   localparam logic [7:0] CTRL_BUBBLE = 8'h00;

   // Extract the ALUOp field from a packed bundle
   function automatic alu_op_e alu_op_of(input logic [7:0] ctrl);
      return alu_op_e'(ctrl[CB_ALU_OP_HI:CB_ALU_OP_LO]);
   endfunction

endpackage

// File: rtl/ctrl_fwd_unit.sv
// Single-operand forwarding compare. A younger producer (EX/MEM) wins over
// an older one (MEM/WB); register 0 is hard-wired and never forwards.
module ctrl_fwd_unit
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic              mem_reg_write_i,
   input  logic [REG_AW-1:0] mem_dst_i,
   input  logic              wb_reg_write_i,
   input  logic [REG_AW-1:0] wb_dst_i,
   output logic [1:0]        sel_o
);

   // Priority select: MEM match, then WB match, else register file
   always_comb begin
      sel_o = FWD_RF;
      if (mem_reg_write_i && (mem_dst_i != '0) && (mem_dst_i == src_i)) begin
         sel_o = FWD_MEM;
      end else if (wb_reg_write_i && (wb_dst_i != '0) && (wb_dst_i == src_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: unpacks the decoder's control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB with the destination register, detects
// load-use hazards (bubble + front-end stall) and drives EX forwarding
// selects. Optional event counters are built when CTRL_PIPE_PERF_EN is
// defined; otherwise the counter ports read constant 0.
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CTRL_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              ex_alu_src_o,
   output logic [1:0]        ex_alu_op_o,
   output logic              ex_reg_dst_o,
   output logic [REG_AW-1:0] ex_dst_o,
   output logic [REG_AW-1:0] mem_dst_o,
   output logic [REG_AW-1:0] wb_dst_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic              wb_reg_write_o,
   output logic              wb_mem_to_reg_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
);

   // ID/EX
   logic [CTRL_W-1:0] ex_ctrl_reg, ex_ctrl_next;
   logic [REG_AW-1:0] ex_rs_reg, ex_rs_next;
   logic [REG_AW-1:0] ex_rt_reg, ex_rt_next;
   logic [REG_AW-1:0] ex_dst_reg, ex_dst_next;
   // EX/MEM
   logic              mem_reg_write_reg, mem_mem_to_reg_reg;
   logic              mem_read_reg, mem_write_reg;
   logic [REG_AW-1:0] mem_dst_reg;
   // MEM/WB
   logic              wb_reg_write_reg, wb_mem_to_reg_reg;
   logic [REG_AW-1:0] wb_dst_reg;

   logic hazard;
   logic bubble;

   // Load in EX whose destination is read by the instruction in ID
   always_comb begin
      hazard = ex_ctrl_reg[CB_MEM_READ] && (ex_dst_reg != '0) &&
               ((ex_dst_reg == id_rs_i) || (ex_dst_reg == id_rt_i));
      // A squashed instruction is discarded anyway, so it never holds the front end
      stall_o = hazard && !flush_i;
      bubble  = flush_i || hazard;
   end

   // ID/EX next values: bubble or the decoded instruction in ID
   always_comb begin
      ex_ctrl_next = ctrl_i;
      ex_rs_next   = id_rs_i;
      ex_rt_next   = id_rt_i;
      ex_dst_next  = ctrl_i[CB_REG_DST] ? id_rd_i : id_rt_i;
      if (bubble) begin
         ex_ctrl_next = CTRL_BUBBLE;
         ex_rs_next   = '0;
         ex_rt_next   = '0;
         ex_dst_next  = '0;
      end
   end

   // Pipeline registers; EX/MEM and MEM/WB advance every cycle regardless of stall
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_ctrl_reg        <= CTRL_BUBBLE;
         ex_rs_reg          <= '0;
         ex_rt_reg          <= '0;
         ex_dst_reg         <= '0;
         mem_reg_write_reg  <= 1'b0;
         mem_mem_to_reg_reg <= 1'b0;
         mem_read_reg       <= 1'b0;
         mem_write_reg      <= 1'b0;
         mem_dst_reg        <= '0;
         wb_reg_write_reg   <= 1'b0;
         wb_mem_to_reg_reg  <= 1'b0;
         wb_dst_reg         <= '0;
      end else begin
         ex_ctrl_reg        <= ex_ctrl_next;
         ex_rs_reg          <= ex_rs_next;
         ex_rt_reg          <= ex_rt_next;
         ex_dst_reg         <= ex_dst_next;
         mem_reg_write_reg  <= ex_ctrl_reg[CB_REG_WRITE];
         mem_mem_to_reg_reg <= ex_ctrl_reg[CB_MEM_TO_REG];
         mem_read_reg       <= ex_ctrl_reg[CB_MEM_READ];
         mem_write_reg      <= ex_ctrl_reg[CB_MEM_WRITE];
         mem_dst_reg        <= ex_dst_reg;
         wb_reg_write_reg   <= mem_reg_write_reg;
         wb_mem_to_reg_reg  <= mem_mem_to_reg_reg;
         wb_dst_reg         <= mem_dst_reg;
      end
   end

   assign ex_alu_src_o    = ex_ctrl_reg[CB_ALU_SRC];
   assign ex_alu_op_o     = alu_op_of(ex_ctrl_reg);
   assign ex_reg_dst_o    = ex_ctrl_reg[CB_REG_DST];
   assign ex_dst_o        = ex_dst_reg;
   assign mem_read_o      = mem_read_reg;
   assign mem_write_o     = mem_write_reg;
   assign mem_dst_o       = mem_dst_reg;
   assign wb_reg_write_o  = wb_reg_write_reg;
   assign wb_mem_to_reg_o = wb_mem_to_reg_reg;
   assign wb_dst_o        = wb_dst_reg;

   // Forwarding: operand 0 is rs (A), operand 1 is rt (B)
   logic [REG_AW-1:0] ex_src [2];
   logic [1:0]        fwd_sel [2];

   assign ex_src[0] = ex_rs_reg;
   assign ex_src[1] = ex_rt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         ctrl_fwd_unit #(
            .REG_AW (REG_AW)
         ) u_fwd (
            .src_i           (ex_src[gi]),
            .mem_reg_write_i (mem_reg_write_reg),
            .mem_dst_i       (mem_dst_reg),
            .wb_reg_write_i  (wb_reg_write_reg),
            .wb_dst_i        (wb_dst_reg),
            .sel_o           (fwd_sel[gi])
         );
      end
   endgenerate

   assign fwd_a_o = fwd_sel[0];
   assign fwd_b_o = fwd_sel[1];

`ifdef CTRL_PIPE_PERF_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] flush_cnt_reg;

   // Saturating stall/flush event counters, cleared only by reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_o && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
         if (flush_i && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
   assign flush_cnt_o = flush_cnt_reg;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a table of per-cycle ID inputs with the
// expected combinational outputs before the edge and the registered stage
// outputs after it, followed by hand-written reset and counter sequences.
module tb_ctrl_pipe;

   localparam logic [7:0] C_R   = 8'b1000_0111;
   localparam logic [7:0] C_LW  = 8'b1110_1000;
   localparam logic [7:0] C_SW  = 8'b0001_1000;
   localparam logic [7:0] C_NOP = 8'h00;
   localparam int         NV    = 27;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  ctrl_i = '0;
   logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o, ex_alu_src_o, ex_reg_dst_o;
   logic [1:0]  ex_alu_op_o, fwd_a_o, fwd_b_o;
   logic [4:0]  ex_dst_o, mem_dst_o, wb_dst_o;
   logic        mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   int n_pass  = 0;
   int n_total = 0;

   ctrl_pipe #(.REG_AW(5), .CTRL_W(8)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .ctrl_i          (ctrl_i),
      .id_rs_i         (id_rs_i),
      .id_rt_i         (id_rt_i),
      .id_rd_i         (id_rd_i),
      .flush_i         (flush_i),
      .stall_o         (stall_o),
      .ex_alu_src_o    (ex_alu_src_o),
      .ex_alu_op_o     (ex_alu_op_o),
      .ex_reg_dst_o    (ex_reg_dst_o),
      .ex_dst_o        (ex_dst_o),
      .mem_dst_o       (mem_dst_o),
      .wb_dst_o        (wb_dst_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .wb_reg_write_o  (wb_reg_write_o),
      .wb_mem_to_reg_o (wb_mem_to_reg_o),
      .fwd_a_o         (fwd_a_o),
      .fwd_b_o         (fwd_b_o),
      .stall_cnt_o     (stall_cnt_o),
      .flush_cnt_o     (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] ctrl;
      logic [4:0] rs, rt, rd;
      logic       flush;
      logic [4:0] pre;   // {stall, fwd_a, fwd_b} before the edge
      logic [8:0] ex;    // {alu_src, alu_op, reg_dst, ex_dst} after the edge
      logic [6:0] mem;   // {mem_read, mem_write, mem_dst}
      logic [6:0] wb;    // {reg_write, mem_to_reg, wb_dst}
   } vec_t;

   vec_t tbl [NV];

   function automatic vec_t mk(input logic [7:0] c, input logic [4:0] rs, rt, rd,
                               input logic fl, input logic st, input logic [1:0] fa, fb,
                               input logic es, input logic [1:0] eo, input logic er,
                               input logic [4:0] ed, input logic mr, mw, input logic [4:0] md,
                               input logic wr, wm, input logic [4:0] wd);
      vec_t v;
      v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.flush = fl;
      v.pre = {st, fa, fb};
      v.ex  = {es, eo, er, ed};
      v.mem = {mr, mw, md};
      v.wb  = {wr, wm, wd};
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic [7:0] c, input logic [4:0] rs, rt, rd, input logic fl);
      ctrl_i = c; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd; flush_i = fl;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [27:0] all_outs();
      return {stall_o, ex_alu_src_o, ex_alu_op_o, ex_reg_dst_o, ex_dst_o, mem_dst_o,
              wb_dst_o, mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o,
              fwd_a_o, fwd_b_o};
   endfunction

   initial begin
      //               ctrl  rs rt rd fl | st fa fb | src op rd dst | mr mw md | wr wm wd
      tbl[0]  = mk(C_R,   1, 2, 3, 0,  0, 0, 0,  0, 3, 1, 3,   0, 0, 0,  0, 0, 0);
      tbl[1]  = mk(C_NOP, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,   0, 0, 3,  0, 0, 0);
      tbl[2]  = mk(C_NOP, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  1, 0, 3);
      tbl[3]  = mk(C_LW,  1, 5, 9, 0,  0, 0, 0,  1, 0, 0, 5,   0, 0, 0,  0, 0, 0);
      // load-use: stall, bubble enters EX, load moves to MEM
      tbl[4]  = mk(C_R,   5, 6, 7, 0,  1, 0, 0,  0, 0, 0, 0,   1, 0, 5,  0, 0, 0);
      tbl[5]  = mk(C_R,   5, 6, 7, 0,  0, 0, 0,  0, 3, 1, 7,   0, 0, 0,  1, 1, 5);
      // dependent now in EX, load already in WB behind the bubble
      tbl[6]  = mk(C_NOP, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0,   0, 0, 7,  0, 0, 0);
      tbl[7]  = mk(C_R,   1, 2, 4, 0,  0, 0, 0,  0, 3, 1, 4,   0, 0, 0,  1, 0, 7);
      tbl[8]  = mk(C_R,   4, 4, 8, 0,  0, 0, 0,  0, 3, 1, 8,   0, 0, 4,  0, 0, 0);
      tbl[9]  = mk(C_NOP, 0, 0, 0, 0,  0, 2, 2,  0, 0, 0, 0,   0, 0, 8,  1, 0, 4);
      tbl[10] = mk(C_R,   1, 2, 4, 0,  0, 0, 0,  0, 3, 1, 4,   0, 0, 0,  1, 0, 8);
      tbl[11] = mk(C_R,   1, 2, 9, 0,  0, 0, 0,  0, 3, 1, 9,   0, 0, 4,  0, 0, 0);
      tbl[12] = mk(C_R,   4, 4,10, 0,  0, 0, 0,  0, 3, 1,10,   0, 0, 9,  1, 0, 4);
      tbl[13] = mk(C_R,   1, 2, 4, 0,  0, 1, 1,  0, 3, 1, 4,   0, 0,10,  1, 0, 9);
      tbl[14] = mk(C_R,   1, 2, 4, 0,  0, 0, 0,  0, 3, 1, 4,   0, 0, 4,  1, 0,10);
      tbl[15] = mk(C_R,   4, 4,11, 0,  0, 0, 0,  0, 3, 1,11,   0, 0, 4,  1, 0, 4);
      tbl[16] = mk(C_NOP, 0, 0, 0, 0,  0, 2, 2,  0, 0, 0, 0,   0, 0,11,  1, 0, 4);
      tbl[17] = mk(C_NOP, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  1, 0,11);
      // load-use hidden by flush
      tbl[18] = mk(C_LW,  1, 6, 0, 0,  0, 0, 0,  1, 0, 0, 6,   0, 0, 0,  0, 0, 0);
      tbl[19] = mk(C_R,   6, 2,12, 1,  0, 0, 0,  0, 0, 0, 0,   1, 0, 6,  0, 0, 0);
      // writes to $0 never forward or stall
      tbl[20] = mk(C_R,   1, 2, 0, 0,  0, 0, 0,  0, 3, 1, 0,   0, 0, 0,  1, 1, 6);
      tbl[21] = mk(C_R,   0, 0,13, 0,  0, 0, 0,  0, 3, 1,13,   0, 0, 0,  0, 0, 0);
      tbl[22] = mk(C_LW,  1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0,   0, 0,13,  1, 0, 0);
      tbl[23] = mk(C_R,   0, 0,14, 0,  0, 0, 0,  0, 3, 1,14,   1, 0, 0,  1, 0,13);
      tbl[24] = mk(C_NOP, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,   0, 0,14,  1, 1, 0);
      tbl[25] = mk(C_SW,  1, 2, 0, 0,  0, 0, 0,  1, 0, 0, 2,   0, 0, 0,  1, 0,14);
      tbl[26] = mk(C_NOP, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,   0, 1, 2,  0, 0, 0);

      // Reset state
      #1;
      step();
      step();
      chk("reset_outs", 0, 32'(all_outs()), 32'd0);
      chk("reset_stall_cnt", 0, stall_cnt_o, 32'd0);
      chk("reset_flush_cnt", 0, flush_cnt_o, 32'd0);
      #2 rst_i = 1'b0;
      step();

      // Table-driven stream
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].flush);
         #1;
         chk("pre_stall_fa_fb", i, 32'({stall_o, fwd_a_o, fwd_b_o}), 32'(tbl[i].pre));
         step();
         chk("ex_stage", i, 32'({ex_alu_src_o, ex_alu_op_o, ex_reg_dst_o, ex_dst_o}),
             32'(tbl[i].ex));
         chk("mem_stage", i, 32'({mem_read_o, mem_write_o, mem_dst_o}), 32'(tbl[i].mem));
         chk("wb_stage", i, 32'({wb_reg_write_o, wb_mem_to_reg_o, wb_dst_o}), 32'(tbl[i].wb));
         $display("vec %0d ctrl=%b rs=%0d rt=%0d rd=%0d flush=%0b", i, tbl[i].ctrl,
                  tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].flush);
      end

      // Asynchronous reset mid-cycle with sw in MEM
      drive(C_NOP, 0, 0, 0, 0);
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_mem_write", 0, 32'(mem_write_o), 32'd0);
      chk("async_rst_outs", 0, 32'(all_outs()), 32'd0);
      step();
      chk("rst_hold_outs", 0, 32'(all_outs()), 32'd0);
      #2 rst_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("post_rst_outs", k, 32'(all_outs()), 32'd0);
      end
      chk("post_rst_stall_cnt", 0, stall_cnt_o, 32'd0);
      chk("post_rst_flush_cnt", 0, flush_cnt_o, 32'd0);
      $display("seq reset: async assert with sw in MEM, release mid-cycle");

      // R-type rd=3 walking EX -> MEM -> WB
      drive(C_R, 1, 2, 3, 0);
      step();
      drive(C_NOP, 0, 0, 0, 0);
      chk("rtype_ex", 0, 32'({ex_alu_op_o, ex_reg_dst_o, ex_dst_o}), 32'({2'b11, 1'b1, 5'd3}));
      step();
      chk("rtype_mem", 0, 32'({mem_read_o, mem_write_o, mem_dst_o}), 32'({2'b00, 5'd3}));
      step();
      chk("rtype_wb", 0, 32'({wb_reg_write_o, wb_mem_to_reg_o, wb_dst_o}),
          32'({2'b10, 5'd3}));
      $display("seq rtype: rd=3 through EX/MEM/WB");

      // Three load-use stalls and two flushes
      for (int k = 0; k < 3; k++) begin
         drive(C_LW, 1, 5, 0, 0);
         step();
         drive(C_R, 5, 6, 7, 0);
         #1;
         chk("perf_stall_seen", k, 32'(stall_o), 32'd1);
         step();
         step();
         drive(C_NOP, 0, 0, 0, 0);
         step();
      end
      drive(C_NOP, 0, 0, 0, 1);
      step();
      step();
      drive(C_NOP, 0, 0, 0, 0);
      step();
`ifdef CTRL_PIPE_PERF_EN
      chk("perf_stall_cnt", 0, stall_cnt_o, 32'd3);
      chk("perf_flush_cnt", 0, flush_cnt_o, 32'd2);
      dut.flush_cnt_reg = 32'hFFFF_FFFE;
      drive(C_NOP, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) step();
      drive(C_NOP, 0, 0, 0, 0);
      step();
      chk("perf_flush_sat", 0, flush_cnt_o, 32'hFFFF_FFFF);
`else
      chk("perf_stall_cnt_off", 0, stall_cnt_o, 32'd0);
      chk("perf_flush_cnt_off", 0, flush_cnt_o, 32'd0);
`endif
      $display("seq perf: 3 stalls, 2 flushes");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
